// File: rtl/alu_seq_pkg.sv
// Shared opcode and state definitions for the registered sequential ALU (alu_seq).
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_XNAND = 3'b001;
    localparam logic [2:0] OP_ANY   = 3'b010;
    localparam logic [2:0] OP_SPLIT = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_RSV   = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative LSB-first shift-add multiplier: one multiplier bit per clock, WIDTH clocks per product.
// done/product are valid in the cycle whose closing edge finishes the multiply, so the owner registers them.
module seq_multiplier
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   multiplicand;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   addend;
    logic [WIDTH-1:0]     multiplier;
    logic [CW-1:0]        count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)         state_next = ST_MUL;
            ST_MUL:  if (count == '0)   state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_MUL);
        done = (state == ST_MUL) && (count == '0);
    end

    // The multiplicand is pre-shifted each step, equivalent to shifting by (WIDTH-1-count).
    assign addend  = multiplier[0] ? multiplicand : '0;
    assign product = partial + addend;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            multiplicand <= '0;
            multiplier   <= '0;
            partial      <= '0;
            count        <= '0;
        end else if (state == ST_IDLE && start) begin
            multiplicand <= {{WIDTH{1'b0}}, a};
            multiplier   <= b;
            partial      <= '0;
            count        <= CNT_INIT;
        end else if (state == ST_MUL) begin
            partial      <= product;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            count        <= count - 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with accumulator feedback, shifts and a multi-cycle multiply.
// Build option: define ALU_SEQ_SAT_EN to make ADD saturate at 2^WIDTH-1.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 use_acc,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero
);

    logic [WIDTH-1:0]     bop;
    logic [SHW-1:0]       shamt;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   alu_value;
    logic                 accept;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    assign bop       = use_acc ? result[WIDTH-1:0] : b;
    assign shamt     = a[SHW-1:0];
    assign accept    = start && !busy;
    assign mul_start = accept && (op == OP_MUL);

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (bop),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        sum       = {1'b0, a} + {1'b0, bop};
        alu_value = '0;
        case (op)
            OP_ADD: begin
`ifdef ALU_SEQ_SAT_EN
                alu_value = {{WIDTH{1'b0}}, sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0]};
`else
                alu_value = {{(WIDTH-1){1'b0}}, sum};
`endif
            end
            OP_XNAND: alu_value = {~(a & bop), ~(a ^ bop)};
            OP_ANY:   alu_value = {{WIDTH{1'b0}}, {WIDTH{|{a, bop}}}};
            OP_SPLIT: alu_value = {a, ~bop};
            OP_SHL:   alu_value = {{WIDTH{1'b0}}, bop} << shamt;
            OP_SHR:   alu_value = {{WIDTH{1'b0}}, bop >> shamt};
            OP_MUL:   alu_value = '0;
            OP_RSV:   alu_value = '0;
            default:  alu_value = '0;
        endcase
    end

    // A finishing multiply and a new accept never coincide: busy is still high on the last step.
    always_ff @(posedge clock) begin
        if (reset) begin
            result <= '0;
            done   <= 1'b0;
        end else if (mul_done) begin
            result <= mul_product;
            done   <= 1'b1;
        end else if (accept && (op != OP_MUL)) begin
            result <= alu_value;
            done   <= 1'b1;
        end else begin
            done   <= 1'b0;
        end
    end

    assign zero = (result == '0);

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the lab 3 switch-driven ALU.
- Operand width is generic (WIDTH), the result is registered, and an accumulator mode feeds the previous result back as operand B.
- Adds shift ops and a multi-cycle shift-add multiply with a start/busy/done handshake.
- Sits between board I/O (SW/KEY decode) and the LEDR/HEX display logic in the top level.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16. The result is 2*WIDTH bits.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from a.

Ports:
- clock  in  1  rising-edge system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  operation request; sampled only in IDLE
- op  in  3  opcode, sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- use_acc  in  1  when 1, operand B = result[WIDTH-1:0] (value held at the start edge)
- busy  out  1  high while the multiply iterates
- done  out  1  one-cycle pulse when result has just been updated
- result  out  2*WIDTH  registered ALU output
- zero  out  1  combinational: result == 0

Behaviour:
- Reset (synchronous, active-high) sets result=0, done=0, busy=0, state=IDLE, multiply counter/partials=0. Reset has priority over start and aborts any multiply in progress; no done pulse is produced.
- Operand B (Bop) = use_acc ? result[WIDTH-1:0] : b. It is captured at the start edge.
- Opcodes (zero-extend every result to 2*WIDTH):
  - 000 ADD: a+Bop, WIDTH+1 bits, carry in bit WIDTH.
  - 001 XNAND: low half = ~(a^Bop), high half = ~(a&Bop).
  - 010 ANY: low WIDTH bits all 1 if |{a,Bop}, else 0.
  - 011 SPLIT: high half = a, low half = ~Bop.
  - 100 SHL: Bop << a[SHW-1:0], full 2*WIDTH kept.
  - 101 SHR: logical, Bop >> a[SHW-1:0].
  - 110 MUL: unsigned a*Bop.
  - 111: reserved; result = 0, done still pulses.
- Single-cycle ops: start=1 in IDLE at edge k. After edge k, result is updated and done=1 for exactly one cycle. State stays IDLE.
- State machine: IDLE, MUL.
  - IDLE -> MUL when start=1 and op=110. Latch multiplicand=a and multiplier=Bop, clear the partial sum, set count=WIDTH-1, busy=1.
  - In MUL, each edge: if multiplier LSB, partial += multiplicand << (WIDTH-1-count)… processed LSB-first; the multiplier shifts right and count decrements.
  - On the edge where count==0 completes, write result=product, done=1, busy=0, state=IDLE.
  - Start at edge k gives busy=1 after edges k..k+WIDTH-1, and result/done after edge k+WIDTH.
  - result holds its old value throughout MUL.
- start while busy is ignored; no queuing.
- start is accepted in the same cycle done=1 (back-to-back operations).
- use_acc with MUL uses the result value from before the multiply starts.
- op/a/b changes after the start edge have no effect.
- zero tracks result continuously, including after reset (zero=1).

Optional Feature:
- Macro: ALU_SEQ_SAT_EN.
- When defined, ADD saturates: if a+Bop >= 2^WIDTH, result = 2^WIDTH-1 (bit WIDTH = 0), otherwise the normal sum.
- When undefined, ADD returns the full WIDTH+1-bit sum including carry.
- All other ops are identical in both builds.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD, OP_XNAND, OP_ANY, OP_SPLIT, OP_SHL, OP_SHR, OP_MUL, OP_RSV
  - state encoding ST_IDLE, ST_MUL
- One sub-module, seq_multiplier: owns the multiplicand/multiplier/partial/count registers, with ports start, a, b, busy, done, product.
- The top-level alu_seq holds the combinational op mux and the result register.

Test Plan (WIDTH=4 unless noted):
- Reset, then ADD a=4'hF b=4'h1 start at edge k -> after k, result=8'h10, done=1 for one cycle, zero=0. With ALU_SEQ_SAT_EN -> result=8'h0F.
- XNAND a=4'b1010 b=4'b0110 -> result=8'b1101_0011. ANY a=0 b=0 -> result=0, zero=1.
- MUL a=4'hD b=4'hB -> busy=1 for 4 cycles, result stays at old value, then result=8'h8F and done pulses once. start asserted mid-multiply with op=ADD -> ignored.
- Accumulator mode: ADD a=3 b=2 (result=5), then ADD a=1 use_acc=1 -> 6, then SHL a=1 use_acc=1 -> 12 (8'h0C). Back-to-back starts each produce a single done.
- Reset asserted on the 2nd cycle of MUL -> next cycle result=0, busy=0, no done. A new ADD then completes normally.
- WIDTH=8: MUL 8'hFF*8'hFF -> result=16'hFE01 after 8 busy cycles. SHR b=8'h80 a=7 -> 16'h0001.
